// File: rtl/if_pc_predictor.sv
// if_pc_predictor
//   IF-stage fetch PC generator with a two-bit dynamic branch predictor.
//   A direct-mapped table holds, per entry, a valid bit, a tag, a branch
//   target (the BTB part) and a two-bit saturating counter (the BHT part).
//   Branch and jump outcomes resolved in EX train the table. A wrong
//   prediction raises a redirect and steers the fetch PC to the correct path.
//
// Ports
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_stall_pc          load-use stall; holds the fetch PC
//   i_ex_*              resolution info for the control instruction in EX
//   o_pc                registered fetch PC
//   o_pred_taken        prediction for o_pc (combinational lookup)
//   o_pred_target       predicted next PC (BTB target, or o_pc+4)
//   o_redirect          mispredict; flush the IF/ID and ID/EX registers
//   o_br_count          number of resolved control instructions
//   o_mispred_count     number of mispredicts
module if_pc_predictor #(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_pc,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic        i_ex_is_jump,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic [31:0] o_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic        o_redirect,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_arr  [BHT_ENTRIES];
  logic [TAG_W-1:0] tag_arr    [BHT_ENTRIES];
  logic [31:0]      target_arr [BHT_ENTRIES];
  logic [1:0]       cnt_arr    [BHT_ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ev;
  logic             mis;
  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;

  assign fetch_idx = o_pc[IDX_W+1:2];
  assign fetch_tag = o_pc[31:IDX_W+2];
  assign ex_idx    = i_ex_pc[IDX_W+1:2];
  assign ex_tag    = i_ex_pc[31:IDX_W+2];

  // Lookups read the flop arrays directly, so a same-cycle write is only
  // seen by the fetch side from the following cycle on.
  assign fetch_hit     = valid_arr[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
  assign ex_hit        = valid_arr[ex_idx] && (tag_arr[ex_idx] == ex_tag);
  assign pc_plus4      = o_pc + 32'd4;
  assign o_pred_taken  = fetch_hit && cnt_arr[fetch_idx][1];
  assign o_pred_target = o_pred_taken ? target_arr[fetch_idx] : pc_plus4;

  // A taken outcome with the right direction but the wrong target still
  // counts as a mispredict.
  assign ev  = i_ex_valid && (i_ex_is_branch || i_ex_is_jump);
  assign mis = ev && ((i_ex_taken != i_ex_pred_taken) ||
                      (i_ex_taken && (i_ex_target != i_ex_pred_target)));
  assign o_redirect = mis;

  // Redirect outranks the load-use stall: the stalled instruction is on the
  // wrong path and is flushed anyway.
  always_comb begin
    next_pc = pc_plus4;
    if (mis)
      next_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
    else if (i_stall_pc)
      next_pc = o_pc;
    else if (o_pred_taken)
      next_pc = o_pred_target;
  end

  // PC register, statistics and predictor training. Training follows EX,
  // so it proceeds even while fetch is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc            <= RESET_PC;
      o_br_count      <= '0;
      o_mispred_count <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_arr[i]  <= 1'b0;
        tag_arr[i]    <= '0;
        target_arr[i] <= '0;
        cnt_arr[i]    <= 2'b01;
      end
    end else begin
      o_pc <= next_pc;
      if (ev) begin
        o_br_count <= o_br_count + 32'd1;
        if (mis)
          o_mispred_count <= o_mispred_count + 32'd1;
        if (i_ex_is_jump) begin
          valid_arr[ex_idx]  <= 1'b1;
          tag_arr[ex_idx]    <= ex_tag;
          target_arr[ex_idx] <= i_ex_target;
          cnt_arr[ex_idx]    <= 2'b11;
        end else if (i_ex_taken) begin
          if (ex_hit) begin
            target_arr[ex_idx] <= i_ex_target;
            if (cnt_arr[ex_idx] != 2'b11)
              cnt_arr[ex_idx] <= cnt_arr[ex_idx] + 2'b01;
          end else begin
            // Allocation evicts whatever branch aliased into this slot.
            valid_arr[ex_idx]  <= 1'b1;
            tag_arr[ex_idx]    <= ex_tag;
            target_arr[ex_idx] <= i_ex_target;
            cnt_arr[ex_idx]    <= 2'b10;
          end
        end else if (ex_hit) begin
          if (cnt_arr[ex_idx] != 2'b00)
            cnt_arr[ex_idx] <= cnt_arr[ex_idx] - 2'b01;
        end
      end
    end
  end

endmodule

// File: doc/if_pc_predictor.md
Name: if_pc_predictor

Overview:
- IF-stage PC generator with a two-bit dynamic branch predictor: a direct-mapped BHT of saturating counters plus a BTB.
- Sits directly upstream of the IF/ID register.
- Consumes the load-use stall from the hazard/forwarding unit.
- Receives branch/jump resolution from EX, produces the fetch PC with its prediction, and raises the pipeline redirect on mispredict.

Parameters:
- BHT_ENTRIES, 64, number of BHT/BTB entries; power of two, >= 4. IDX_W = log2(BHT_ENTRIES).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_stall_pc  input  1  load-use stall from hazard unit; hold PC.
- i_ex_valid  input  1  EX holds a valid control instruction this cycle.
- i_ex_is_branch  input  1  EX instruction is a conditional branch.
- i_ex_is_jump  input  1  EX instruction is JAL/JALR.
- i_ex_pc  input  32  PC of the EX instruction.
- i_ex_taken  input  1  actual outcome (1 for jumps).
- i_ex_target  input  32  actual taken target.
- i_ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- i_ex_pred_target  input  32  predicted target carried down the pipe.
- o_pc  output  32  current fetch PC (registered).
- o_pred_taken  output  1  prediction for o_pc (combinational from o_pc).
- o_pred_target  output  32  predicted next PC when o_pred_taken=1, else o_pc+4.
- o_redirect  output  1  mispredict; flush IF/ID and ID/EX this cycle.
- o_br_count  output  32  resolved control instructions.
- o_mispred_count  output  32  mispredicts.

Behaviour:
- Reset (sync, i_rst=1 at edge):
  - o_pc=RESET_PC.
  - All BTB valid=0, all counters=2'b01 (weakly not-taken).
  - Both stat counters=0.
  - Reset overrides every other input; applies mid-operation identically.
- Index/tag:
  - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - Lookup: hit = valid[idx] && tag match.
  - o_pred_taken = hit && cnt[idx][1].
- Table reads are asynchronous from flop arrays.
- A write and a read to the same entry in the same cycle: the read returns the old value; the new value is visible next cycle.
- Resolve event: ev = i_ex_valid && (i_ex_is_branch || i_ex_is_jump).
- Mispredict:
  - mis = ev && ((i_ex_taken != i_ex_pred_taken) || (i_ex_taken && i_ex_target != i_ex_pred_target)).
  - o_redirect = mis, combinational, same cycle.
- Next-PC priority at each edge:
  1. i_rst → RESET_PC.
  2. mis → (i_ex_taken ? i_ex_target : i_ex_pc+4).
  3. i_stall_pc → hold o_pc.
  4. o_pred_taken → BTB target.
  5. Otherwise o_pc+4.
- Redirect beats stall.
- PC arithmetic is 32-bit and wraps modulo 2^32. Bits [1:0] pass through unchanged and are never checked.
- Table update on ev, using the EX idx/tag. Updates happen regardless of i_stall_pc.
  - Jump: write valid=1, tag, target=i_ex_target, cnt=2'b11.
  - Branch taken, hit: cnt saturating +1 (2'b11 stays); target rewritten.
  - Branch taken, miss: allocate valid=1, tag, target, cnt=2'b10 (evicts the old entry).
  - Branch not taken, hit: cnt saturating -1 (2'b00 stays).
  - Branch not taken, miss: no change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Only bit[1] drives the prediction.
- Statistics:
  - o_br_count +1 per ev.
  - o_mispred_count +1 per mis.
  - Both wrap at 2^32 without saturation.
- i_ex_valid=0 → no table, stat, or redirect effect, whatever the other EX inputs are.

Test Plan:
1. Reset, no events, no stall for 4 cycles → o_pc = 0,4,8,C; o_pred_taken=0; o_redirect=0.
2. Branch at PC 0x20, taken to 0x10:
   - First resolve with pred_taken=0 → o_redirect=1; next o_pc=0x10; entry cnt=10.
   - Next fetch of 0x20 → o_pred_taken=1, o_pred_target=0x10.
   - Two more taken resolves → cnt=11 and stays 11.
3. Train entry to 11, resolve not-taken twice:
   - First: mis=1, redirect to 0x24, cnt=10, prediction still taken.
   - Second: cnt=01, fetch of 0x20 now predicts not-taken.
4. i_stall_pc=1 for 2 cycles at o_pc=0x40 → o_pc holds 0x40; released → 0x44. Stall held with a simultaneous mispredict to 0x80 → o_pc=0x80 next cycle.
5. JAL at 0x100 to 0x200 (BTB miss, pred_taken=0) → redirect; entry cnt=11; next fetch of 0x100 predicts 0x200. An aliasing PC 0x100+4*BHT_ENTRIES → miss, predicts not-taken.
6. Assert i_rst mid-run after 5 resolves (2 mispredicts) → counters 0; o_pc=RESET_PC; previously trained PC predicts not-taken.
